// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: drives open-drain clock/data enables, device clocks the frame.
// Optional automatic resend on NACK or timeout is enabled by defining PS2_HOST_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE   = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam bit            INH_ONE   = (INHIBIT_CYCLES == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_n;
  logic [9:0]      r_frame, w_frame_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [3:0]      r_bit, w_bit_n;
  logic            r_nack, w_nack_n;
  logic [RW-1:0]   r_retry, w_retry_n;
  logic            r_clk_oe, w_clk_oe_n;
  logic            r_dat_oe, w_dat_oe_n;
  logic            r_done, w_done_n;
  logic            r_err, w_err_n;
  logic            w_fail;

  logic r_clk_p0, r_clk_p1, r_clk_p2;
  logic r_dat_p0, r_dat_p1;
  logic w_fall;
  logic w_can_retry;
  logic w_watch;

  assign w_fall      = r_clk_p2 & ~r_clk_p1;
  assign w_can_retry = RETRY_EN && (r_retry < RETRY_LIM);
  assign w_watch     = (r_state == S_RTS) || (r_state == S_SHIFT) ||
                       (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

  always_ff @(posedge clk) begin
    // p0/p1: two-flop synchronizers; p2: previous synced clock for edge detect
    r_clk_p0 <= ps2_clk_in;
    r_clk_p1 <= r_clk_p0;
    r_clk_p2 <= r_clk_p1;
    r_dat_p0 <= ps2_dat_in;
    r_dat_p1 <= r_dat_p0;
    r_frame  <= w_frame_n;
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_nack   <= 1'b0;
      r_retry  <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_bit    <= w_bit_n;
      r_nack   <= w_nack_n;
      r_retry  <= w_retry_n;
      r_clk_oe <= w_clk_oe_n;
      r_dat_oe <= w_dat_oe_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_frame_n  = r_frame;
    w_cnt_n    = r_cnt;
    w_bit_n    = r_bit;
    w_nack_n   = r_nack;
    w_retry_n  = r_retry;
    w_clk_oe_n = r_clk_oe;
    w_dat_oe_n = r_dat_oe;
    w_done_n   = 1'b0;
    w_err_n    = 1'b0;
    w_fail     = 1'b0;

    // Once the device owns the clock, any gap between falling edges is bounded.
    if (w_watch) begin
      if (w_fall)                w_cnt_n = '0;
      else if (r_cnt == TO_LAST) w_fail  = 1'b1;
      else                       w_cnt_n = r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_frame_n  = {1'b1, ~^tx_data, tx_data};
          w_cnt_n    = '0;
          w_retry_n  = '0;
          w_clk_oe_n = 1'b1;
          w_dat_oe_n = INH_ONE;
          w_state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_cnt_n = r_cnt + 1'b1;
        if (r_cnt == INH_PRE) w_dat_oe_n = 1'b1;
        if (r_cnt == INH_LAST) begin
          w_cnt_n    = '0;
          w_clk_oe_n = 1'b0;
          w_dat_oe_n = 1'b1;
          w_state_n  = S_RTS;
        end
      end
      S_RTS: begin
        if (w_fall) begin
          w_dat_oe_n = ~r_frame[0];
          w_bit_n    = 4'd1;
          w_state_n  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Falling edge k presents frame bit k-1; the tenth releases the line for the stop bit.
        if (w_fall) begin
          w_dat_oe_n = ~r_frame[r_bit];
          w_bit_n    = r_bit + 4'd1;
          if (r_bit == 4'd9) w_state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_nack_n  = r_dat_p1;
          w_state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (r_clk_p1 && r_dat_p1) begin
          w_fail     = r_nack;
          w_done_n   = ~r_nack;
          w_clk_oe_n = 1'b0;
          w_dat_oe_n = 1'b0;
          w_state_n  = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_fail) begin
      if (w_can_retry) begin
        w_retry_n  = r_retry + 1'b1;
        w_cnt_n    = '0;
        w_clk_oe_n = 1'b1;
        w_dat_oe_n = INH_ONE;
        w_state_n  = S_INHIBIT;
      end else begin
        w_err_n    = 1'b1;
        w_clk_oe_n = 1'b0;
        w_dat_oe_n = 1'b0;
        w_state_n  = S_IDLE;
      end
    end
  end

  assign tx_ready   = (r_state == S_IDLE);
  assign tx_busy    = (r_state != S_IDLE);
  assign tx_done    = r_done;
  assign tx_err     = r_err;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and checks bits and handshakes.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO  = 2000;
  localparam int HALF = 500;

`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;
  logic       line_clk, line_dat;

  assign line_clk = dev_clk & ~ps2_clk_oe;
  assign line_dat = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_err(tx_err),
    .ps2_clk_in(line_clk),
    .ps2_dat_in(line_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_inh = 0;
  int n_misalign = 0;
  int n_busy_drop = 0;
  bit watch = 1'b0;
  logic prev_clk_oe = 1'b0;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if ((tx_done || tx_err) && !tx_ready) n_misalign++;
    if (ps2_clk_oe && !prev_clk_oe) n_inh++;
    prev_clk_oe = ps2_clk_oe;
    if (watch) begin
      if (tx_done) watch = 1'b0;
      else if (!tx_busy) n_busy_drop++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected line levels at the device's sampling points: start, data LSB first, odd parity, stop.
  function automatic int exp_frame(input int d);
    int f;
    f = 0;
    for (int i = 0; i < 8; i++) f += ((d >> i) & 1) << (i + 1);
    f += (($countones(d & 255) % 2 == 0) ? 1 : 0) << 9;
    f += 1 << 10;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input int half, input bit nack, input int abort_at,
                           output logic [10:0] bits, output int inh);
    int g;
    bits = '0;
    inh  = 0;
    g    = 0;
    while (!ps2_clk_oe && g < 1000) begin tick(); g++; end
    chk("inhibit_seen", int'(ps2_clk_oe), 1);
    while (ps2_clk_oe && inh < 10000) begin inh++; tick(); end
    bits[0] = line_dat;
    repeat (half) tick();
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == abort_at) begin
        repeat (10) tick();
        return;
      end
      repeat (half) tick();
      dev_clk = 1'b1;
      if (k == 11) begin
        dev_dat = 1'b1;
        return;
      end
      bits[k] = line_dat;
      if (k == 10) begin
        repeat (half / 2) tick();
        dev_dat = nack;
        repeat (half - half / 2) tick();
      end else begin
        repeat (half) tick();
      end
    end
  endtask

  task automatic xfer(input logic [7:0] d, input int half, input bit nack, input string tag);
    int d0, e0, inh, w;
    logic [10:0] bits;
    d0 = n_done;
    e0 = n_err;
    chk({tag, "_ready_before"}, int'(tx_ready), 1);
    send(d);
    chk({tag, "_busy"}, int'(tx_busy), 1);
    dev_frame(half, nack, 0, bits, inh);
    chk({tag, "_inhibit_len"}, inh, INH);
    chk({tag, "_bits"}, int'(bits), exp_frame(int'(d)));
    w = 0;
    while (!tx_ready && w < 100) begin tick(); w++; end
    repeat (2) tick();
    chk({tag, "_ready_after"}, int'(tx_ready), 1);
    chk({tag, "_done_pulses"}, n_done - d0, nack ? 0 : 1);
    chk({tag, "_err_pulses"}, n_err - e0, nack ? 1 : 0);
    chk({tag, "_oe_idle"}, int'({ps2_clk_oe, ps2_dat_oe}), 0);
  endtask

  initial begin
    int d0, e0, t, inh, ab;
    logic [10:0] bits;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (4) tick();
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_err", int'(tx_err), 0);
    chk("rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    rst = 1'b0;
    repeat (5) tick();

    xfer(8'hED, HALF, 1'b0, "ed");
    xfer(8'h01, HALF, 1'b0, "x01");
    xfer(8'hFF, HALF, 1'b0, "xff");

`ifdef PS2_HOST_TX_RETRY_EN
    d0 = n_done;
    e0 = n_err;
    t  = n_inh;
    send(8'h3C);
    watch = 1'b1;
    for (int a = 0; a < 3; a++) begin
      dev_frame(HALF, (a < 2), 0, bits, inh);
      chk("retry_inhibit_len", inh, INH);
      chk("retry_bits", int'(bits), exp_frame(8'h3C));
    end
    t = n_inh - t;
    inh = 0;
    while (!tx_ready && inh < 100) begin tick(); inh++; end
    repeat (2) tick();
    chk("retry_inhibit_phases", t, 3);
    chk("retry_busy_drops", n_busy_drop, 0);
    chk("retry_done", n_done - d0, 1);
    chk("retry_err", n_err - e0, 0);
`else
    xfer(8'h5A, HALF, 1'b1, "nack");

    d0 = n_done;
    e0 = n_err;
    send(8'hA5);
    t = 0;
    while (ps2_clk_oe && t < 10000) begin tick(); t++; end
    chk("to_inhibit_len", t, INH);
    t = 0;
    while (!tx_err && t < 3000) begin tick(); t++; end
    chk("to_latency", t, TO);
    chk("to_oe_released", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("to_ready", int'(tx_ready), 1);
    repeat (2) tick();
    chk("to_err_pulses", n_err - e0, 1);
    chk("to_done_pulses", n_done - d0, 0);
`endif

    // Abort a transfer by reset after the fifth device clock edge.
    ab = 8'h86;
    d0 = n_done;
    e0 = n_err;
    send(8'h86);
    dev_frame(HALF, 1'b0, 5, bits, inh);
    chk("abort_inhibit_len", inh, INH);
    chk("abort_data_drive", int'(ps2_dat_oe), ((ab >> 4) & 1) ^ 1);
    rst     = 1'b1;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    tick();
    chk("abort_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("abort_ready", int'(tx_ready), 1);
    rst = 1'b0;
    repeat (5) tick();
    chk("abort_done_pulses", n_done - d0, 0);
    chk("abort_err_pulses", n_err - e0, 0);
    xfer(8'hF4, HALF, 1'b0, "f4");

    for (int i = 0; i < 4; i++) begin
      logic [7:0] rd;
      int rh;
      bit rn;
      rd = 8'($urandom_range(0, 255));
      rh = int'($urandom_range(40, 120));
      rn = RETRY ? 1'b0 : ($urandom_range(0, 3) == 0);
      xfer(rd, rh, rn, "rand");
    end

    chk("pulse_align", n_misalign, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends single command/data bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic rate.
- Shares the open-drain PS2_CLK/PS2_DAT lines with the existing keyboard receive path.
- The top level combines the `*_oe` outputs into tri-state drivers: drive low when oe=1, otherwise Z.
- Exposes `tx_busy` so the receive path ignores the lines while a transmit is in progress.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles the host holds PS2 clock low before request-to-send (120 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles allowed between device clock falling edges, and before the first one (15 ms).
- MAX_RETRY, 2: automatic resend attempts; used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- rst  in  1  synchronous reset, active-high.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: byte acknowledged by device.
- tx_err  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  in  1  raw PS2 clock line level.
- ps2_dat_in  in  1  raw PS2 data line level.
- ps2_clk_oe  out  1  1 = pull PS2 clock low.
- ps2_dat_oe  out  1  1 = pull PS2 data low.

Behaviour:
- Inputs `ps2_clk_in` and `ps2_dat_in` each pass through a 2-flop synchronizer.
- Falling edge = synced clock was 1 last cycle and is 0 now. Edge detection lags the line by 3 cycles.
- Reset values: state IDLE; tx_ready=1; tx_busy=0; tx_done=0; tx_err=0; ps2_clk_oe=0; ps2_dat_oe=0; counters 0.
- Reset taken mid-transfer releases both lines on the next clock edge. No done/err pulse is generated.
- Accept: in IDLE with tx_valid=1, latch the frame as {1'b1 stop, odd parity, tx_data}. Odd parity = ~^tx_data. Go to INHIBIT.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. In the final cycle assert ps2_dat_oe=1 (start bit). Go to RTS.
- RTS: ps2_clk_oe=0 and ps2_dat_oe=1. Wait for falling edge #1, then go to SHIFT.
- SHIFT: edges are counted from the first falling edge of the clock.
  - Edges 1-8: set ps2_dat_oe = ~bit, LSB first.
  - Edge 9: set ps2_dat_oe = ~parity.
  - Edge 10: ps2_dat_oe=0 (stop bit, line released). Go to ACK.
- ACK: on edge 11, sample synced data. 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1.
  - After an ACK, pulse tx_done.
  - After a NACK, pulse tx_err.
  - The pulse occurs in the same cycle as the return to IDLE. tx_ready rises the same cycle.
- Timeout:
  - Counter clears on every falling edge and on entry to RTS.
  - In RTS, SHIFT, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both oe, pulses tx_err and returns to IDLE.
- tx_valid is ignored while busy. tx_data is sampled only at accept.
- oe outputs are registered; there is no combinational path from inputs to outputs.
- Extra falling edges after ACK are ignored. A device-initiated frame is not possible while busy because the host owns the bus.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - A NACK or timeout, while retry count < MAX_RETRY, restarts at INHIBIT with the same latched frame. No tx_err pulse is generated and tx_busy stays high.
  - The retry count resets on accept.
  - tx_err pulses only after MAX_RETRY+1 failed attempts.
- Undefined: the first failure pulses tx_err. MAX_RETRY is unused.

Test Plan:
- Bench setup for all scenarios: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=2000, a device model that clocks at 20 µs period, and the retry feature off.
- Send 0xED, device ACKs -> clk_oe low-pull held exactly 100 cycles. Bits seen at device rising edges: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. Exactly one tx_done pulse, no tx_err, tx_ready returns to 1.
- Send 0x01 -> parity bit 0. Send 0xFF -> parity 1. Both receive ACK, one tx_done each.
- Device holds data high on edge 11 (NACK) -> one tx_err pulse, no tx_done, both oe=0 in IDLE.
- Device never clocks after RTS -> tx_err pulses 2000 cycles after RTS entry. Both oe released the same cycle.
- Assert rst at edge 5 of a transfer -> next cycle both oe=0, tx_ready=1, no done/err pulse. A new 0xF4 transfer then completes normally.
- With PS2_HOST_TX_RETRY_EN defined and MAX_RETRY=2, device NACKs twice then ACKs -> 3 INHIBIT phases, tx_busy high throughout, single tx_done, no tx_err.
